// File: rtl/tile_gather_if.sv
// Bundle of control, scratchpad-read and PE-array handshake signals for tile_gather.
// The master modport is the loader's view; the slave modport is the view of
// the environment around it (sequencer, scratchpad, PE array).
interface tile_gather_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int PE_ROW = 4,
    parameter int PE_COL = 4,
    parameter int LANES  = 1
) ();
    localparam int N = PE_ROW * PE_COL;

    logic [1:0]              work_mode;
    logic                    start;
    logic [AWIDTH-1:0]       base_addr;
    logic [AWIDTH-1:0]       row_stride;
    logic                    rd_en;
    logic [AWIDTH-1:0]       rd_addr;
    logic [LANES*DWIDTH-1:0] rd_data;
    logic                    rd_valid;
    logic [N*DWIDTH-1:0]     tile;
    logic                    tile_valid;
    logic                    tile_ready;
    logic [1:0]              pe_mode;
    logic                    busy;
    logic                    done;

    modport master (
        input  work_mode, start, base_addr, row_stride, rd_data, rd_valid, tile_ready,
        output rd_en, rd_addr, tile, tile_valid, pe_mode, busy, done
    );

    modport slave (
        output work_mode, start, base_addr, row_stride, rd_data, rd_valid, tile_ready,
        input  rd_en, rd_addr, tile, tile_valid, pe_mode, busy, done
    );
endinterface

// File: rtl/tile_gather.sv
// Operand-tile loader: issues strided scratchpad reads, packs the returned beats
// into one flat tile and offers it to the PE array with a valid/ready handshake.
// Issue and return counters run independently so a return may coincide with an
// issue; an abort drains the outstanding returns in FLUSH before going idle.
module tile_gather #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int PE_ROW = 4,
    parameter int PE_COL = 4,
    parameter int LANES  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    tile_gather_if.master bus
);
    localparam int N     = PE_ROW * PE_COL;
    localparam int BEATS = N / LANES;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int IW    = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]     LAST_BEAT = CW'(BEATS - 1);
    localparam logic [CW-1:0]     ONE_C     = CW'(1);
    localparam logic [AWIDTH-1:0] COL_STEP  = AWIDTH'(LANES);
    localparam logic [AWIDTH-1:0] COL_LAST  = AWIDTH'(PE_COL - LANES);
    localparam logic [IW-1:0]     ELEM_STEP = IW'(LANES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD, S_FLUSH} state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   row_addr_q;
    logic [AWIDTH-1:0]   stride_q;
    logic [AWIDTH-1:0]   col_q;
    logic [CW-1:0]       issued_q;
    logic [CW-1:0]       returned_q;
    logic [IW-1:0]       ret_elem_q;
    logic [DWIDTH-1:0]   tile_q [N];
    logic [1:0]          pe_mode_q;
    logic                done_q;
    logic [N*DWIDTH-1:0] tile_flat;

    logic          issuing;
    logic          ret_accept;
    logic          ret_store;
    logic          abort;
    logic          last_issue;
    logic          last_return;
    logic          start_load;
    logic [CW-1:0] outstanding;

    function automatic logic [1:0] map_mode(input logic [1:0] wm);
        case (wm)
            2'b10:   return 2'b01;
            2'b11:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Decode of issue/return events; returns are only taken while some are owed
    always_comb begin
        issuing     = (state_q == S_FETCH);
        outstanding = issued_q - returned_q;
        ret_accept  = bus.rd_valid && (outstanding != '0) &&
                      (state_q inside {S_FETCH, S_DRAIN, S_FLUSH});
        ret_store   = ret_accept && (state_q != S_FLUSH);
        abort       = (bus.work_mode == 2'b00);
        last_issue  = issuing && (issued_q == LAST_BEAT);
        last_return = ret_store && (returned_q == LAST_BEAT);
        start_load  = bus.start && bus.work_mode[1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_load) state_d = S_FETCH;
            S_FETCH: begin
                if (abort)           state_d = S_FLUSH;
                else if (last_issue) state_d = last_return ? S_HOLD : S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)            state_d = S_FLUSH;
                else if (last_return) state_d = S_HOLD;
            end
            S_HOLD:  if (bus.tile_ready) state_d = S_IDLE;
            S_FLUSH: if (outstanding == CW'(ret_accept)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Address walk and issue/return counters; row address steps by stride at row end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_addr_q <= '0;
            stride_q   <= '0;
            col_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            ret_elem_q <= '0;
        end else if ((state_q == S_IDLE) && start_load) begin
            row_addr_q <= bus.base_addr;
            stride_q   <= bus.row_stride;
            col_q      <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            ret_elem_q <= '0;
        end else begin
            if (issuing) begin
                issued_q <= issued_q + ONE_C;
                if (col_q == COL_LAST) begin
                    col_q      <= '0;
                    row_addr_q <= row_addr_q + stride_q;
                end else begin
                    col_q <= col_q + COL_STEP;
                end
            end
            if (ret_accept) returned_q <= returned_q + ONE_C;
            if (ret_store)  ret_elem_q <= ret_elem_q + ELEM_STEP;
        end
    end

    // Tile storage: lane j of a returned beat lands at element ret_elem+j (lane 0 = MSBs)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) tile_q[k] <= '0;
        end else if (ret_store) begin
            for (int j = 0; j < LANES; j++)
                tile_q[ret_elem_q + IW'(j)] <= bus.rd_data[(LANES-j)*DWIDTH-1 -: DWIDTH];
        end
    end

    // PE mode follows work_mode while idle and freezes for the tile in flight; done pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pe_mode_q <= 2'b00;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == S_HOLD) && bus.tile_ready;
            if (state_q == S_IDLE) pe_mode_q <= map_mode(bus.work_mode);
        end
    end

    // Element k occupies the k-th DWIDTH slice counted from the MSB end
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign tile_flat[N*DWIDTH-1-gi*DWIDTH -: DWIDTH] = tile_q[gi];
    end

    // Outputs decoded from state and registers
    always_comb begin
        bus.rd_en      = (state_q == S_FETCH);
        bus.rd_addr    = row_addr_q + col_q;
        bus.tile       = tile_flat;
        bus.tile_valid = (state_q == S_HOLD);
        bus.pe_mode    = pe_mode_q;
        bus.busy       = (state_q != S_IDLE);
        bus.done       = done_q;
    end
endmodule

// File: tb/tb_tile_gather.sv
// Bench for tile_gather: a LANES=1 and a LANES=2 instance, each behind a
// fixed-latency scratchpad model returning data equal to the read address.
module tb_tile_gather;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    tile_gather_if #(.LANES(1)) bus1 ();
    tile_gather_if #(.LANES(2)) bus2 ();

    tile_gather #(.DWIDTH(16), .AWIDTH(16), .PE_ROW(4), .PE_COL(4), .LANES(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    tile_gather #(.DWIDTH(16), .AWIDTH(16), .PE_ROW(4), .PE_COL(4), .LANES(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int          due;
        logic [15:0] addr;
    } req_t;

    req_t        mq1[$];
    req_t        mq2[$];
    logic [15:0] obs_a1[$];
    int          obs_c1[$];
    logic [15:0] obs_a2[$];
    int          obs_c2[$];
    logic [15:0] exp_a[$];
    int          exp_c[$];
    logic [255:0] sb_tile[$];
    int lat1 = 1;
    int lat2 = 1;
    bit stray1 = 1'b0;

    // Scratchpad model for the LANES=1 instance
    always @(negedge clk) begin : mem1
        req_t r;
        if (bus1.rd_en === 1'b1) begin
            r.due  = cyc + lat1;
            r.addr = bus1.rd_addr;
            mq1.push_back(r);
            obs_a1.push_back(bus1.rd_addr);
            obs_c1.push_back(cyc);
        end
        if (mq1.size() > 0 && mq1[0].due <= cyc) begin
            bus1.rd_valid = 1'b1;
            bus1.rd_data  = mq1[0].addr;
            void'(mq1.pop_front());
        end else begin
            bus1.rd_valid = stray1;
            bus1.rd_data  = 16'hDEAD;
        end
    end

    // Scratchpad model for the LANES=2 instance: lane 0 = addr, lane 1 = addr+1
    always @(negedge clk) begin : mem2
        req_t r;
        if (bus2.rd_en === 1'b1) begin
            r.due  = cyc + lat2;
            r.addr = bus2.rd_addr;
            mq2.push_back(r);
            obs_a2.push_back(bus2.rd_addr);
            obs_c2.push_back(cyc);
        end
        if (mq2.size() > 0 && mq2[0].due <= cyc) begin
            bus2.rd_valid = 1'b1;
            bus2.rd_data  = {mq2[0].addr, mq2[0].addr + 16'd1};
            void'(mq2.pop_front());
        end else begin
            bus2.rd_valid = 1'b0;
            bus2.rd_data  = '0;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus1.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset rd_en: got %b expected 0", bus1.rd_en); end
        n_checks++; if (bus1.rd_addr !== 16'h0) begin n_fail++; $display("FAIL reset rd_addr: got %h expected 0000", bus1.rd_addr); end
        n_checks++; if (bus1.tile !== '0) begin n_fail++; $display("FAIL reset tile: got %h expected 0", bus1.tile); end
        n_checks++; if (bus1.tile_valid !== 1'b0) begin n_fail++; $display("FAIL reset tile_valid: got %b expected 0", bus1.tile_valid); end
        n_checks++; if (bus1.pe_mode !== 2'b00) begin n_fail++; $display("FAIL reset pe_mode: got %b expected 00", bus1.pe_mode); end
        n_checks++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset busy/done: got %b/%b expected 0/0", bus1.busy, bus1.done); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset: outputs checked");
    endtask

    // One tile load on the LANES=1 instance; hold>0 keeps tile_ready low that many cycles
    task automatic load1(input string name, input logic [1:0] mode, input logic [15:0] base,
                         input logic [15:0] stride, input int lat, input int hold);
        int c0, tv, oc;
        logic [255:0] et, exp_tile;
        logic [1:0] em;
        logic [15:0] a, oa, ea;
        bit seen;
        lat1 = lat;
        obs_a1.delete(); obs_c1.delete(); exp_a.delete(); exp_c.delete();
        c0 = cyc;
        et = '0;
        for (int b = 0; b < 16; b++) begin
            a = base + stride * 16'(b / 4) + 16'(b % 4);
            exp_a.push_back(a);
            exp_c.push_back(c0 + 1 + b);
            et[255-16*b -: 16] = a;
        end
        sb_tile.push_back(et);
        em = (mode == 2'b10) ? 2'b01 : 2'b11;
        bus1.work_mode  = mode;
        bus1.base_addr  = base;
        bus1.row_stride = stride;
        bus1.start      = 1'b1;
        bus1.tile_ready = (hold == 0);
        @(negedge clk);
        bus1.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus1.tile_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s tile_valid timeout: got 0 expected 1 within 100 cycles", name);
            return;
        end
        tv = cyc;
        n_checks++; if (tv != c0 + 16 + lat + 1) begin n_fail++; $display("FAIL %s tile_valid cycle: got +%0d expected +%0d", name, tv - c0, 16 + lat + 1); end
        exp_tile = sb_tile.pop_front();
        n_checks++; if (bus1.tile !== exp_tile) begin n_fail++; $display("FAIL %s tile: got %h expected %h", name, bus1.tile, exp_tile); end
        n_checks++; if (bus1.pe_mode !== em) begin n_fail++; $display("FAIL %s pe_mode: got %b expected %b", name, bus1.pe_mode, em); end
        n_checks++; if (obs_a1.size() != 16) begin n_fail++; $display("FAIL %s beat count: got %0d expected 16", name, obs_a1.size()); end
        while (exp_a.size() > 0 && obs_a1.size() > 0) begin
            ea = exp_a.pop_front(); oa = obs_a1.pop_front();
            oc = obs_c1.pop_front();
            n_checks++;
            if (oa !== ea || oc != exp_c[0]) begin
                n_fail++;
                $display("FAIL %s rd_addr: got %h at +%0d expected %h at +%0d", name, oa, oc - c0, ea, exp_c[0] - c0);
            end
            void'(exp_c.pop_front());
        end
        for (int i = 0; i < hold; i++) begin
            bus1.start     = 1'($urandom_range(0, 1));
            bus1.work_mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            n_checks++;
            if (bus1.tile_valid !== 1'b1 || bus1.tile !== exp_tile || bus1.pe_mode !== em ||
                bus1.rd_en !== 1'b0 || bus1.done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s hold cycle %0d: got valid=%b mode=%b rd_en=%b done=%b tile_ok=%b expected 1/%b/0/0/1",
                         name, i, bus1.tile_valid, bus1.pe_mode, bus1.rd_en, bus1.done, bus1.tile === exp_tile, em);
            end
        end
        bus1.start      = 1'b0;
        bus1.work_mode  = mode;
        bus1.tile_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus1.done !== 1'b1 || bus1.tile_valid !== 1'b0 || bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handshake: got done=%b valid=%b busy=%b expected 1/0/0", name, bus1.done, bus1.tile_valid, bus1.busy);
        end
        $display("txn %s: base=%h stride=%h tile_valid at +%0d, pe_mode=%b, hold=%0d", name, base, stride, tv - c0, bus1.pe_mode, hold);
    endtask

    task automatic test_basic();
        load1("basic", 2'b10, 16'h0100, 16'h0004, 1, 0);
    endtask

    task automatic test_wrap();
        load1("wrap", 2'b10, 16'hFFFE, 16'h0020, 2, 0);
    endtask

    task automatic test_back_to_back();
        // called right at the done cycle, so start is offered at h+1
        load1("back_to_back", 2'b11, 16'h1234, 16'h0100, 1, 0);
    endtask

    task automatic test_backpressure();
        load1("backpressure", 2'b10, 16'h0500, 16'h0010, 2, 10);
        @(negedge clk);
        n_checks++; if (bus1.done !== 1'b0) begin n_fail++; $display("FAIL backpressure done width: got %b expected 0", bus1.done); end
    endtask

    task automatic test_lanes2();
        int c0, tv;
        logic [255:0] et, exp_tile;
        logic [15:0] ea, oa;
        bit seen;
        lat2 = 3;
        obs_a2.delete(); obs_c2.delete(); exp_a.delete();
        et = '0;
        for (int k = 0; k < 16; k++)
            et[255-16*k -: 16] = 16'h0040 + 16'h0010 * 16'(k / 4) + 16'(k % 4);
        for (int b = 0; b < 8; b++)
            exp_a.push_back(16'h0040 + 16'h0010 * 16'((2 * b) / 4) + 16'((2 * b) % 4));
        sb_tile.push_back(et);
        c0 = cyc;
        bus2.work_mode = 2'b11; bus2.base_addr = 16'h0040; bus2.row_stride = 16'h0010;
        bus2.start = 1'b1; bus2.tile_ready = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus2.tile_valid === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL lanes2 tile_valid timeout: got 0 expected 1 within 100 cycles"); return; end
        tv = cyc;
        n_checks++; if (tv != c0 + 8 + 3 + 1) begin n_fail++; $display("FAIL lanes2 tile_valid cycle: got +%0d expected +12", tv - c0); end
        exp_tile = sb_tile.pop_front();
        n_checks++; if (bus2.tile !== exp_tile) begin n_fail++; $display("FAIL lanes2 tile: got %h expected %h", bus2.tile, exp_tile); end
        n_checks++; if (bus2.pe_mode !== 2'b11) begin n_fail++; $display("FAIL lanes2 pe_mode: got %b expected 11", bus2.pe_mode); end
        n_checks++; if (obs_a2.size() != 8) begin n_fail++; $display("FAIL lanes2 beat count: got %0d expected 8", obs_a2.size()); end
        while (exp_a.size() > 0 && obs_a2.size() > 0) begin
            ea = exp_a.pop_front(); oa = obs_a2.pop_front();
            n_checks++;
            if (oa !== ea) begin n_fail++; $display("FAIL lanes2 rd_addr: got %h expected %h", oa, ea); end
        end
        @(negedge clk);
        n_checks++; if (bus2.done !== 1'b1 || bus2.busy !== 1'b0) begin n_fail++; $display("FAIL lanes2 handshake: got done=%b busy=%b expected 1/0", bus2.done, bus2.busy); end
        bus2.work_mode = 2'b00;
        $display("txn lanes2: base=0040 stride=0010 tile_valid at +%0d", tv - c0);
    endtask

    task automatic test_abort();
        int c0;
        bit bad;
        lat1 = 4;
        obs_a1.delete(); obs_c1.delete();
        c0 = cyc;
        bus1.work_mode = 2'b10; bus1.base_addr = 16'h0200; bus1.row_stride = 16'h0008;
        bus1.start = 1'b1; bus1.tile_ready = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (4) @(negedge clk);
        bus1.work_mode = 2'b00;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus1.tile_valid !== 1'b0 || bus1.done !== 1'b0) bad = 1'b1;
        end
        n_checks++; if (obs_a1.size() != 5) begin n_fail++; $display("FAIL abort beats issued: got %0d expected 5", obs_a1.size()); end
        n_checks++; if (bad) begin n_fail++; $display("FAIL abort tile_valid/done: got asserted expected never"); end
        n_checks++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL abort idle after flush: got busy=%b expected 0", bus1.busy); end
        $display("txn abort: %0d beats issued before abort", obs_a1.size());
        load1("after_abort", 2'b10, 16'h0300, 16'h0004, 2, 0);
    endtask

    task automatic test_reset_mid();
        bit bad;
        lat1 = 3;
        bus1.work_mode = 2'b10; bus1.base_addr = 16'h0700; bus1.row_stride = 16'h0004;
        bus1.start = 1'b1; bus1.tile_ready = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        bus1.work_mode = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if (bus1.rd_en !== 1'b0 || bus1.rd_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mid rd_en/rd_addr: got %b/%h expected 0/0000", bus1.rd_en, bus1.rd_addr); end
        n_checks++; if (bus1.tile !== '0 || bus1.tile_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid tile: got %h valid=%b expected 0/0", bus1.tile, bus1.tile_valid); end
        n_checks++; if (bus1.pe_mode !== 2'b00 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin n_fail++; $display("FAIL reset_mid mode/busy/done: got %b/%b/%b expected 00/0/0", bus1.pe_mode, bus1.busy, bus1.done); end
        stray1 = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus1.tile !== '0 || bus1.tile_valid !== 1'b0 || bus1.busy !== 1'b0) bad = 1'b1;
        end
        stray1 = 1'b0;
        n_checks++; if (bad) begin n_fail++; $display("FAIL reset_mid stray return: got tile/valid/busy changed expected all 0"); end
        $display("txn reset_mid: stray returns ignored");
    endtask

    initial begin
        bus1.work_mode = 2'b00; bus1.start = 1'b0; bus1.base_addr = '0; bus1.row_stride = '0; bus1.tile_ready = 1'b0;
        bus2.work_mode = 2'b00; bus2.start = 1'b0; bus2.base_addr = '0; bus2.row_stride = '0; bus2.tile_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_lanes2();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
